// File: rtl/shifter_pkg.sv
// Shared mode encoding and stage-count helper for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSR = 2'b00,
    SH_ASR = 2'b01,
    SH_LSL = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_e;

  // Register stages needed when each stage absorbs `stride` power-of-two layers.
  function automatic int calc_stages(input int width, input int stride);
    int layers;
    layers = $clog2(width);
    return (layers + stride - 1) / stride;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational shift layer of fixed distance DIST; zero latency, no flow control.
// Sticky accumulation of right-shifted-out bits only exists when STICKY_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  shift_mode_e      mode,
  input  logic             sel,
  input  logic             sticky_in,
  output logic [WIDTH-1:0] data_out,
  output logic             sticky_out
);

  always_comb begin
    data_out = data;
    if (sel) begin
      case (mode)
        SH_LSR:  data_out = data >> DIST;
        SH_ASR:  data_out = WIDTH'($signed(data) >>> DIST);
        SH_LSL:  data_out = data << DIST;
        default: data_out = (data >> DIST) | (data << (WIDTH - DIST));
      endcase
    end
  end

`ifdef STICKY_EN
  logic lost;

  // Only right shifts discard precision below bit 0.
  assign lost       = sel && ((mode == SH_LSR) || (mode == SH_ASR)) && (|data[DIST-1:0]);
  assign sticky_out = sticky_in | lost;
`else
  assign sticky_out = sticky_in;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter, latency STAGES cycles, one beat/cycle; whole pipe stalls when
// out_valid & ~out_ready (in_ready = out_ready | ~out_valid). Optional sticky output: STICKY_EN.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STRIDE = 1,
  parameter int TAG_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_sticky
);

  localparam int LAYERS = $clog2(WIDTH);
  localparam int STAGES = calc_stages(WIDTH, PIPE_STRIDE);

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  dat_q  [STAGES];
  logic [LAYERS-1:0] amt_q  [STAGES];
  shift_mode_e       mode_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];

  logic [STAGES-1:0] src_vld;
  logic [WIDTH-1:0]  src_dat  [STAGES];
  logic [LAYERS-1:0] src_amt  [STAGES];
  shift_mode_e       src_mode [STAGES];
  logic [TAG_W-1:0]  src_tag  [STAGES];
  logic [STAGES-1:0] src_sticky;
  logic [WIDTH-1:0]  stage_dat [STAGES];

  logic [WIDTH-1:0]  lay_dat [LAYERS];
  logic [LAYERS-1:0] lay_sticky;
  logic [STAGES-1:0] pipe_unused;
  logic              advance;

`ifdef STICKY_EN
  logic [STAGES-1:0] sticky_q;
  logic [STAGES-1:0] stage_sticky;
`else
  logic              sticky_unused;
`endif

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LAST = ((s + 1) * PIPE_STRIDE < LAYERS) ? (s + 1) * PIPE_STRIDE - 1 : LAYERS - 1;

    if (s == 0) begin : g_head
      assign src_vld[s]  = in_valid;
      assign src_dat[s]  = in_data;
      assign src_amt[s]  = in_amt;
      assign src_mode[s] = shift_mode_e'(in_mode);
      assign src_tag[s]  = in_tag;
    end else begin : g_body
      assign src_vld[s]  = vld_q[s-1];
      assign src_dat[s]  = dat_q[s-1];
      assign src_amt[s]  = amt_q[s-1];
      assign src_mode[s] = mode_q[s-1];
      assign src_tag[s]  = tag_q[s-1];
    end

    assign stage_dat[s] = lay_dat[LAST];
    // The last stage's control fields and already-consumed amt bits have no reader.
    assign pipe_unused[s] = ^{amt_q[s], mode_q[s]};

`ifdef STICKY_EN
    if (s == 0) begin : g_sticky_head
      assign src_sticky[s] = 1'b0;
    end else begin : g_sticky_body
      assign src_sticky[s] = sticky_q[s-1];
    end
    assign stage_sticky[s] = lay_sticky[LAST];
`endif
  end

`ifndef STICKY_EN
  assign src_sticky    = '0;
  assign sticky_unused = |lay_sticky;
`endif

  // Layers run MSB-first: layer j applies distance 2^(LAYERS-1-j).
  for (genvar j = 0; j < LAYERS; j++) begin : g_layer
    localparam int S = j / PIPE_STRIDE;
    localparam int K = LAYERS - 1 - j;

    logic [WIDTH-1:0] d_in;
    logic             st_in;

    if (j % PIPE_STRIDE == 0) begin : g_first
      assign d_in  = src_dat[S];
      assign st_in = src_sticky[S];
    end else begin : g_chain
      assign d_in  = lay_dat[j-1];
      assign st_in = lay_sticky[j-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << K)
    ) u_shift (
      .data       (d_in),
      .mode       (src_mode[S]),
      .sel        (src_amt[S][K]),
      .sticky_in  (st_in),
      .data_out   (lay_dat[j]),
      .sticky_out (lay_sticky[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s]  <= '0;
        amt_q[s]  <= '0;
        mode_q[s] <= SH_LSR;
        tag_q[s]  <= '0;
      end
    end else if (advance) begin
      vld_q <= src_vld;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s]  <= stage_dat[s];
        amt_q[s]  <= src_amt[s];
        mode_q[s] <= src_mode[s];
        tag_q[s]  <= src_tag[s];
      end
    end
  end

`ifdef STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (advance) begin
      sticky_q <= stage_sticky;
    end
  end

  assign out_sticky = sticky_q[STAGES-1];
`else
  assign out_sticky = 1'b0;
`endif

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (WIDTH=8, PIPE_STRIDE=1, 3 stages); honours STICKY_EN.
module tb_pipelined_barrel_shifter;

  typedef struct packed {
    logic       s;
    logic [3:0] t;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [7:0] ed;
    logic       es;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_tag;
  logic       out_sticky;

  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  int   out_cnt = 0;
  exp_t drv_exp;
  exp_t exp_q[$];
  int   acc_cycs[$];
  int   out_cycs[$];
  vec_t vecs[16];

  pipelined_barrel_shifter #(
    .WIDTH       (8),
    .PIPE_STRIDE (1),
    .TAG_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_sticky (out_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic logic gate(input logic s);
`ifdef STICKY_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  // Reference result {sticky, data} computed directly from the full shift amount.
  function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
    logic [7:0]  r;
    logic [15:0] dd;
    logic        s;
    s  = 1'b0;
    dd = {d, d} >> a;
    case (m)
      2'd0:    r = d >> a;
      2'd1:    r = 8'($signed(d) >>> a);
      2'd2:    r = d << a;
      default: r = dd[7:0];
    endcase
    if (m < 2'd2)
      for (int i = 0; i < 8; i++)
        if (i < int'(a) && d[i]) s = 1'b1;
    return {gate(s), r};
  endfunction

  // Scoreboard: push on accept, pop and compare on emit; reset discards everything in flight.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_exp);
        acc_cycs.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        out_cycs.push_back(cyc);
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got data=%h tag=%h, expected no beat", out_data, out_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat{sticky,tag,data}", 32'({out_sticky, out_tag, out_data}), 32'(e));
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                      input logic [3:0] t, input exp_t e);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    in_tag   = t;
    drv_exp  = e;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_rand(input logic [3:0] t);
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [8:0] r;
    d = 8'($urandom);
    a = 3'($urandom_range(0, 7));
    m = 2'($urandom_range(0, 3));
    r = model(d, a, m);
    send(d, a, m, t, '{s: r[8], t: t, d: r[7:0]});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'hB4, 3'd3, 2'd0, 8'h16, 1'b1};
    vecs[1]  = '{8'hB4, 3'd3, 2'd1, 8'hF6, 1'b1};
    vecs[2]  = '{8'hB4, 3'd3, 2'd2, 8'hA0, 1'b0};
    vecs[3]  = '{8'hB4, 3'd3, 2'd3, 8'h96, 1'b0};
    vecs[4]  = '{8'h5A, 3'd0, 2'd0, 8'h5A, 1'b0};
    vecs[5]  = '{8'h5A, 3'd0, 2'd1, 8'h5A, 1'b0};
    vecs[6]  = '{8'hA5, 3'd0, 2'd2, 8'hA5, 1'b0};
    vecs[7]  = '{8'hA5, 3'd0, 2'd3, 8'hA5, 1'b0};
    vecs[8]  = '{8'h80, 3'd7, 2'd1, 8'hFF, 1'b0};
    vecs[9]  = '{8'h80, 3'd7, 2'd0, 8'h01, 1'b0};
    vecs[10] = '{8'h80, 3'd7, 2'd2, 8'h00, 1'b0};
    vecs[11] = '{8'h80, 3'd7, 2'd3, 8'h01, 1'b0};
    vecs[12] = '{8'h01, 3'd7, 2'd0, 8'h00, 1'b1};
    vecs[13] = '{8'h7F, 3'd1, 2'd1, 8'h3F, 1'b1};
    vecs[14] = '{8'hC3, 3'd4, 2'd3, 8'h3C, 1'b0};
    vecs[15] = '{8'hC3, 3'd2, 2'd2, 8'h0C, 1'b0};

    // Reset, with a beat offered that must not be accepted.
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    in_amt    = 3'd1;
    in_mode   = 2'd0;
    in_tag    = 4'hE;
    drv_exp   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_sticky", 32'(out_sticky), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    out_cnt  = 0;
    repeat (6) @(posedge clk);
    #1;
    check("no_beat_from_reset_offer", 32'(out_cnt), 32'd0);

    // Directed vectors, back to back.
    acc_cycs.delete();
    out_cycs.delete();
    for (int i = 0; i < 16; i++)
      send(vecs[i].d, vecs[i].a, vecs[i].m, 4'(i),
           '{s: gate(vecs[i].es), t: 4'(i), d: vecs[i].ed});
    in_valid = 1'b0;
    drain("drain_table");
    if (acc_cycs.size() > 0 && out_cycs.size() > 0)
      check("latency_cycles", 32'(out_cycs[0] - acc_cycs[0]), 32'd3);
    else
      check("latency_samples", 32'(out_cycs.size()), 32'd16);

    // 16 random beats, tags 0..15: one result per cycle.
    acc_cycs.delete();
    out_cycs.delete();
    for (int i = 0; i < 16; i++) send_rand(4'(i));
    in_valid = 1'b0;
    drain("drain_stream");
    check("stream_count", 32'(out_cycs.size()), 32'd16);
    if (out_cycs.size() == 16) begin
      check("stream_span", 32'(out_cycs[15] - out_cycs[0]), 32'd15);
      check("stream_first_latency", 32'(out_cycs[0] - acc_cycs[0]), 32'd3);
    end

    // Output stall with a full pipe.
    out_cnt = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand(4'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          if (exp_q.size() > 0)
            check("stall_hold{tag,data}", 32'({out_tag, out_data}), 32'({exp_q[0].t, exp_q[0].d}));
          else
            check("stall_queue", 32'(exp_q.size()), 32'd3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    check("stall_beat_count", 32'(out_cnt), 32'd12);

    // Reset with two beats in flight.
    send_rand(4'hA);
    send_rand(4'hB);
    rst      = 1'b1;
    in_valid = 1'b0;
    out_cnt  = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale_beats", 32'(out_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
